note_tracker_multi: RTL



---
 rtl/note_tracker_pkg.sv | 26 ++
 rtl/note_tracker_if.sv | 22 ++
 rtl/note_tracker_multi_fifo.sv | 56 +++++
 rtl/note_tracker_multi.sv | 127 ++++++++++++
 4 files changed

// File: rtl/note_tracker_pkg.sv
// Shared types and default tables for the multi-channel note tracker.
// Instrument index 0..3 = bd, sd, closed hat, open hat.
package note_tracker_pkg;

  localparam int NT_N         = 4;
  localparam int NT_KEY_W     = 7;
  localparam int NT_VEL_W     = 7;
  localparam int NT_SCALE_OFS = 31;

  function automatic int acc_w(input int iw, input int fw);
    return iw + fw;
  endfunction

  localparam logic [NT_N-1:0][6:0] NT_MIDI_KEYS =
    {7'd46, 7'd42, 7'd38, 7'd36};
  localparam logic [NT_N-1:0][7:0] NT_BASE_DECAY =
    {8'h06, 8'h0C, 8'h12, 8'h25};
  localparam logic [NT_N-1:0][1:0] NT_CHOKE_GROUP =
    {2'd1, 2'd1, 2'd0, 2'd0};

  typedef struct packed {
    logic [NT_KEY_W-1:0] key;
    logic [NT_VEL_W-1:0] velocity;
  } note_event_t;

endpackage

// File: rtl/note_tracker_if.sv
// MIDI note event handshake bundle.
// master drives valid/key/velocity, slave returns ready.
interface note_tracker_if
  import note_tracker_pkg::*;
#(
  parameter int VEL_W = NT_VEL_W
);
  logic             midi_valid;
  logic             midi_ready;
  logic [6:0]       midi_key;
  logic [VEL_W-1:0] midi_velocity;

  modport master (
    output midi_valid, midi_key, midi_velocity,
    input  midi_ready
  );

  modport slave (
    input  midi_valid, midi_key, midi_velocity,
    output midi_ready
  );
endinterface

// File: rtl/note_tracker_multi_fifo.sv
// Synchronous note event FIFO with registered ready (= not full).
// Ports: clk_pixel, rst_n, i_valid/o_ready/i_data push side, i_pop/o_data/o_empty pop side.
module note_event_fifo
  import note_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_pixel,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  note_event_t i_data,
  input  logic        i_pop,
  output note_event_t o_data,
  output logic        o_empty
);
  localparam int AW = $clog2(DEPTH);

  note_event_t   r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ready;
  logic [AW:0]   w_cnt_nxt;
  logic          w_push;
  logic          w_pop;

  assign w_push    = i_valid && r_ready;
  assign w_pop     = i_pop && (r_cnt != '0);
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push)
                   - (AW+1)'(w_pop);
  assign o_ready   = r_ready;
  assign o_empty   = (r_cnt == '0);
  assign o_data    = r_mem[r_rp];

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt   <= w_cnt_nxt;
      // ready is registered off the next count so no
      // combinational path from pop/new_frame reaches it
      r_ready <= (w_cnt_nxt != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

endmodule

// File: rtl/note_tracker_multi.sv
// Per-instrument intensity tracker with frame decay and choke groups.
// Ports: clk_pixel, rst_n, midi (slave if), pitch, decay_mode, new_frame, inst_intensity, inst_hit.
module note_tracker_multi
  import note_tracker_pkg::*;
#(
  parameter int INSTRUMENT_COUNT = NT_N,
  parameter int VEL_W            = NT_VEL_W,
  parameter int INTENSITY_W      = 8,
  parameter int FRAC_W           = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int EXP_SHIFT        = 4,
  parameter logic [INSTRUMENT_COUNT-1:0][6:0] MIDI_KEYS   = NT_MIDI_KEYS,
  parameter logic [INSTRUMENT_COUNT-1:0][7:0] BASE_DECAY  = NT_BASE_DECAY,
  parameter logic [INSTRUMENT_COUNT-1:0][1:0] CHOKE_GROUP = NT_CHOKE_GROUP
) (
  input  logic clk_pixel,
  input  logic rst_n,
  note_tracker_if.slave midi,
  input  logic [9:0] pitch,
  input  logic       decay_mode,
  input  logic       new_frame,
  output logic [INSTRUMENT_COUNT-1:0][INTENSITY_W-1:0] inst_intensity,
  output logic [INSTRUMENT_COUNT-1:0]                  inst_hit
);
  localparam int ACC_W = acc_w(INTENSITY_W, FRAC_W);
  localparam int CW    = (ACC_W > 17) ? ACC_W : 17;

  logic [ACC_W-1:0]            r_acc [INSTRUMENT_COUNT];
  logic [INSTRUMENT_COUNT-1:0] r_pend;
  logic [8:0]                  r_scale;

  note_event_t                 w_ev_in;
  note_event_t                 w_ev;
  logic                        w_empty;
  logic                        w_pop;
  logic [INSTRUMENT_COUNT-1:0] w_match;
  logic [INSTRUMENT_COUNT-1:0] w_choke;
  logic [16:0]                 w_dlin [INSTRUMENT_COUNT];
  logic [ACC_W-1:0]            w_dexp [INSTRUMENT_COUNT];
  logic [ACC_W-1:0]            w_dec  [INSTRUMENT_COUNT];
  logic                        w_unused_pitch;

  assign w_unused_pitch   = ^pitch[1:0];
  assign w_ev_in.key      = midi.midi_key;
  assign w_ev_in.velocity = NT_VEL_W'(midi.midi_velocity);
  assign w_pop            = !w_empty && !new_frame;

  note_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .i_valid   (midi.midi_valid),
    .o_ready   (midi.midi_ready),
    .i_data    (w_ev_in),
    .i_pop     (!new_frame),
    .o_data    (w_ev),
    .o_empty   (w_empty)
  );

  always_comb begin
    w_match = '0;
    w_choke = '0;
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      w_match[i] = (w_ev.key == MIDI_KEYS[i])
                && (w_ev.velocity != '0);
    end
    // a hit silences the other members of its group
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      for (int j = 0; j < INSTRUMENT_COUNT; j++) begin
        if (i != j && w_match[j]
            && CHOKE_GROUP[j] != '0
            && CHOKE_GROUP[j] == CHOKE_GROUP[i])
          w_choke[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      w_dlin[i] = 17'(BASE_DECAY[i]) * 17'(r_scale);
      w_dexp[i] = r_acc[i] >> EXP_SHIFT;
      // small nonzero values still creep down to zero
      if (w_dexp[i] == '0 && r_acc[i] != '0)
        w_dexp[i] = ACC_W'(1);
      if (decay_mode)
        w_dec[i] = r_acc[i] - w_dexp[i];
      else if (CW'(r_acc[i]) > CW'(w_dlin[i]))
        w_dec[i] = ACC_W'(CW'(r_acc[i]) - CW'(w_dlin[i]));
      else
        w_dec[i] = '0;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++)
        r_acc[i] <= '0;
      r_pend         <= '0;
      r_scale        <= '0;
      inst_intensity <= '0;
      inst_hit       <= '0;
    end else begin
      r_scale <= 9'(pitch[9:2]) - 9'(pitch[9:5])
               + 9'(NT_SCALE_OFS);
      if (new_frame) begin
        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
          inst_intensity[i] <= r_acc[i][ACC_W-1:FRAC_W];
          inst_hit[i]       <= r_pend[i];
          r_pend[i]         <= 1'b0;
          r_acc[i]          <= w_dec[i];
        end
      end else if (w_pop) begin
        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
          if (w_match[i]) begin
            r_acc[i]  <= ACC_W'(w_ev.velocity)
                      << (ACC_W - VEL_W);
            r_pend[i] <= 1'b1;
          end else if (w_choke[i]) begin
            r_acc[i]  <= '0;
          end
        end
      end
    end
  end

endmodule
